// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS IF stage with PC, IF/ID register, stall/flush/branch, NOP halt and bad-PC fault
module mips_fetch_stage #(
  parameter int          IMEM_BYTES = 256,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          NOP_HALT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [IMEM_BYTES],
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault
);
  localparam int AW = $clog2(IMEM_BYTES);
  localparam int CW = $clog2(NOP_HALT + 1);
  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] nop_cnt, nop_n;
  logic [AW-1:0] a;
  logic [31:0] word, pc_n, ins_n, pc4_n;
  logic valid_n, bad;
  assign a = pc[AW-1:0];
  assign word = {instruction_mem[a + AW'(3)], instruction_mem[a + AW'(2)],
                 instruction_mem[a + AW'(1)], instruction_mem[a]};
  assign bad = (pc[1:0] != 2'd0) || (pc > 32'(IMEM_BYTES - 4));
  assign halted = state == HALTED;
  assign fetch_fault = state == FAULT;
  always_comb begin
    state_n = state;
    pc_n = pc;
    ins_n = 32'd0;
    pc4_n = 32'd0;
    valid_n = 1'b0;
    nop_n = nop_cnt;
    if (state == RUN) begin
      if (bad) state_n = FAULT;
      else if (branch_taken) pc_n = branch_target;
      else if (flush) pc_n = stall ? pc : pc + 32'd4;
      else if (stall) begin
        ins_n = if_id_instruction;
        pc4_n = if_id_pc_plus4;
        valid_n = if_id_valid;
      end else begin
        ins_n = word;
        pc4_n = pc + 32'd4;
        valid_n = 1'b1;
        pc_n = pc + 32'd4;
        nop_n = (word != 32'd0) ? '0 : nop_cnt + CW'(1);
        if (word == 32'd0 && nop_cnt + CW'(1) == CW'(NOP_HALT)) state_n = HALTED;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      if_id_instruction <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid <= 1'b0;
      nop_cnt <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_id_instruction <= ins_n;
      if_id_pc_plus4 <= pc4_n;
      if_id_valid <= valid_n;
      nop_cnt <= nop_n;
    end
  end
endmodule
